// File: rtl/time_display_mux.sv
// Four-digit multiplexed HH:MM driver for a common-anode 7-segment display.
// Snapshots the time once per scan frame, converts it to BCD and blinks the selected fields.
module time_display_mux #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [1:0] blink_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned   PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [7:0]    FRAME_LAST = 8'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        SLOT_MIN_ONES = 2'd0,
        SLOT_MIN_TENS = 2'd1,
        SLOT_HR_ONES  = 2'd2,
        SLOT_HR_TENS  = 2'd3
    } slot_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic bcd_t to_bcd(input logic [5:0] value);
        bcd_t result;
        result.tens = 4'(value / 6'd10);
        result.ones = 4'(value % 6'd10);
        return result;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    slot_e         slot_q, slot_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
    logic [4:0]    hours_snap_q, hours_snap_d;
    logic [5:0]    minutes_snap_q, minutes_snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          paused_q, paused_d;

    logic          tick;
    logic          frame_start;

    // Scan sequencing: prescaler, digit slot, snapshot capture and blink phase.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        presc_d        = presc_q;
        slot_d         = slot_q;
        frame_cnt_d    = frame_cnt_q;
        phase_d        = phase_q;
        hours_snap_d   = hours_snap_q;
        minutes_snap_d = minutes_snap_q;

        tick        = en && (presc_q == PRESC_LAST);
        frame_start = tick && (slot_q == SLOT_HR_TENS);

        if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            slot_d = slot_e'(slot_q + 2'd1);
        end

        if (frame_start) begin
            hours_snap_d   = hours;
            minutes_snap_d = minutes;
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    bcd_t       hr_bcd, min_bcd;
    logic       hr_valid, min_valid;
    logic [3:0] digit;
    logic       field_valid;
    logic       field_blink;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // Content for the slot about to be shown, taken from next-state values so that a
    // frame-start tick already displays the freshly captured snapshot in slot 0.
    always_comb begin
        hr_bcd      = to_bcd({1'b0, hours_snap_d});
        min_bcd     = to_bcd(minutes_snap_d);
        hr_valid    = (hours_snap_d <= 5'd23);
        min_valid   = (minutes_snap_d <= 6'd59);
        digit       = min_bcd.ones;
        field_valid = min_valid;
        field_blink = blink_sel[1];

        case (slot_d)
            SLOT_MIN_ONES: begin
                digit       = min_bcd.ones;
                field_valid = min_valid;
                field_blink = blink_sel[1];
            end
            SLOT_MIN_TENS: begin
                digit       = min_bcd.tens;
                field_valid = min_valid;
                field_blink = blink_sel[1];
            end
            SLOT_HR_ONES: begin
                digit       = hr_bcd.ones;
                field_valid = hr_valid;
                field_blink = blink_sel[0];
            end
            SLOT_HR_TENS: begin
                digit       = hr_bcd.tens;
                field_valid = hr_valid;
                field_blink = blink_sel[0];
            end
            default: ;
        endcase

        seg_next = field_valid ? seg_encode(digit) : SEG_DASH;

        // A blinked field keeps its anode dark; segments are still driven.
        an_next = 4'b1111;
        if (!(phase_d && field_blink)) begin
            an_next[slot_d] = 1'b0;
        end

        dp_next = !((slot_d == SLOT_HR_ONES) && !phase_d);
    end

    // Output registers: blank while disabled, reload on each tick or on resume.
    always_comb begin
        an_d     = an_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        paused_d = paused_q;

        if (!en) begin
            an_d     = 4'b1111;
            dp_d     = 1'b1;
            paused_d = 1'b1;
        end else if (tick || paused_q) begin
            an_d     = an_next;
            seg_d    = seg_next;
            dp_d     = dp_next;
            paused_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q        <= '0;
            slot_q         <= SLOT_MIN_ONES;
            frame_cnt_q    <= '0;
            phase_q        <= 1'b0;
            hours_snap_q   <= '0;
            minutes_snap_q <= '0;
            an_q           <= 4'b1111;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
            paused_q       <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            slot_q         <= slot_d;
            frame_cnt_q    <= frame_cnt_d;
            phase_q        <= phase_d;
            hours_snap_q   <= hours_snap_d;
            minutes_snap_q <= minutes_snap_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            paused_q       <= paused_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
